// File: rtl/id_ex_latch_pkg.sv
// Shared types for the ID/EX stage: decoded bundle, ALU opcodes and latch FSM states.
// Pure declarations, no logic; imported by the interface, top and tests.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_BEQ  = 4'd10,
    ALU_BNE  = 4'd11,
    ALU_LUI  = 4'd12
  } aluop_t;

  typedef struct packed {
    word_t    pc;
    word_t    instr;
    regbits_t rsel1;
    regbits_t rsel2;
    regbits_t wsel;
    word_t    imm;
    word_t    rdat1;
    word_t    rdat2;
    aluop_t   aluop;
    logic     MemRead;
    logic     MemWrite;
    logic     RegWrite;
    logic     datomic;
    logic     halt;
  } id_ex_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } latch_state_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_latch_if.sv
// ID/EX stage bus: hazard/fetch/memory controls and ID bundle in; EX bundle, status and counters out.
// The hazard/ID side uses master, the latch uses slave.
interface id_ex_latch_if #(parameter int CNT_W = 16);
  import cpu_types_pkg::*;

  logic             ihit;
  logic             mem_req;
  logic             dhit;
  logic             stall;
  logic             flush;
  id_ex_t           id_in;
  id_ex_t           ex_out;
  logic             ex_valid;
  logic             halted;
  logic             freeze;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ihit, mem_req, dhit, stall, flush, id_in,
    input  ex_out, ex_valid, halted, freeze, bubble_cnt, flush_cnt
  );

  modport slave (
    input  ihit, mem_req, dhit, stall, flush, id_in,
    output ex_out, ex_valid, halted, freeze, bubble_cnt, flush_cnt
  );

endinterface

// File: rtl/id_ex_latch_sat_counter.sv
// Saturating up-counter: increments by one on inc, sticks at all-ones, sync active-high clear.
// Count is visible one cycle after inc; no backpressure.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register: 1-cycle ID->EX; stall/miss insert bubbles, flush squashes,
// data-memory wait freezes the stage (and upstream via freeze) with flushes deferred to release.
module id_ex_latch
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic         CLK,
  input logic         RST,
  id_ex_latch_if.slave bus
);

  latch_state_t r_state;
  latch_state_t w_state_nxt;
  id_ex_t       r_ex;
  id_ex_t       w_ex_nxt;
  logic         r_valid;
  logic         w_valid_nxt;
  logic         r_halted;
  logic         w_halted_nxt;
  logic         r_flush_pend;
  logic         w_flush_pend_nxt;
  logic         w_mem_wait;
  logic         w_bub_inc;
  logic         w_flush_inc;
  logic [CNT_W-1:0] w_bubble_cnt;
  logic [CNT_W-1:0] w_flush_cnt;

  assign w_mem_wait = bus.mem_req & ~bus.dhit;

  always_comb begin
    w_state_nxt      = r_state;
    w_ex_nxt         = r_ex;
    w_valid_nxt      = r_valid;
    w_halted_nxt     = r_halted;
    w_flush_pend_nxt = r_flush_pend;
    w_bub_inc        = 1'b0;
    w_flush_inc      = 1'b0;
    case (r_state)
      RUN, HOLD: begin
        if (r_valid && r_ex.halt) begin
          w_state_nxt  = HALTED;
          w_halted_nxt = 1'b1;
        end else if (w_mem_wait) begin
          // Stalls during the wait are dropped; the hazard unit re-decides after release.
          w_state_nxt = HOLD;
          if (bus.flush) begin
            w_flush_pend_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = RUN;
          if (bus.flush || r_flush_pend) begin
            w_ex_nxt         = ID_EX_BUBBLE;
            w_valid_nxt      = 1'b0;
            w_flush_inc      = 1'b1;
            w_flush_pend_nxt = 1'b0;
          end else if (bus.stall || !bus.ihit) begin
            w_ex_nxt    = ID_EX_BUBBLE;
            w_valid_nxt = 1'b0;
            w_bub_inc   = 1'b1;
          end else begin
            w_ex_nxt    = bus.id_in;
            w_valid_nxt = 1'b1;
          end
        end
      end
      HALTED: begin
        w_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= RUN;
      r_ex         <= ID_EX_BUBBLE;
      r_valid      <= 1'b0;
      r_halted     <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ex         <= w_ex_nxt;
      r_valid      <= w_valid_nxt;
      r_halted     <= w_halted_nxt;
      r_flush_pend <= w_flush_pend_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (w_bub_inc),
    .count (w_bubble_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (w_flush_inc),
    .count (w_flush_cnt)
  );

  assign bus.ex_out     = r_ex;
  assign bus.ex_valid   = r_valid;
  assign bus.halted     = r_halted;
  assign bus.freeze     = w_mem_wait & ~r_halted;
  assign bus.bubble_cnt = w_bubble_cnt;
  assign bus.flush_cnt  = w_flush_cnt;

endmodule

// File: tb/tb_id_ex_latch.sv
// Drives a 16-bit-counter and a 2-bit-counter latch with identical stimulus and checks both
// against a cycle-level reference model of the stage behaviour.
module tb_id_ex_latch;
  import cpu_types_pkg::*;

  logic   clk;
  logic   rst;
  logic   ihit, mem_req, dhit, stall, flush;
  id_ex_t id_in;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // reference model state
  id_ex_t      m_ex;
  logic        m_valid, m_halted, m_pend;
  int unsigned m_bc16, m_fc16, m_bc2, m_fc2;

  id_ex_latch_if #(.CNT_W(16)) bus16 ();
  id_ex_latch_if #(.CNT_W(2))  bus2 ();

  assign bus16.ihit = ihit;  assign bus2.ihit = ihit;
  assign bus16.mem_req = mem_req;  assign bus2.mem_req = mem_req;
  assign bus16.dhit = dhit;  assign bus2.dhit = dhit;
  assign bus16.stall = stall;  assign bus2.stall = stall;
  assign bus16.flush = flush;  assign bus2.flush = flush;
  assign bus16.id_in = id_in;  assign bus2.id_in = id_in;

  id_ex_latch #(.CNT_W(16)) u_dut16 (.CLK(clk), .RST(rst), .bus(bus16));
  id_ex_latch #(.CNT_W(2))  u_dut2  (.CLK(clk), .RST(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
  endtask

  task automatic rand_id(input logic [31:0] pc, input logic h, output id_ex_t v);
    v.pc       = pc;
    v.instr    = $urandom;
    v.rsel1    = regbits_t'($urandom_range(0, 31));
    v.rsel2    = regbits_t'($urandom_range(0, 31));
    v.wsel     = regbits_t'($urandom_range(0, 31));
    v.imm      = $urandom;
    v.rdat1    = $urandom;
    v.rdat2    = $urandom;
    v.aluop    = aluop_t'(4'($urandom_range(0, 12)));
    v.MemRead  = 1'($urandom_range(0, 1));
    v.MemWrite = 1'($urandom_range(0, 1));
    v.RegWrite = 1'($urandom_range(0, 1));
    v.datomic  = 1'($urandom_range(0, 1));
    v.halt     = h;
  endtask

  // One clock of the specified behaviour; HOLD needs no separate tracking because a
  // held stage and a running stage react identically to mem_wait.
  task automatic model_step();
    if (rst) begin
      m_ex = '0; m_valid = 0; m_halted = 0; m_pend = 0;
      m_bc16 = 0; m_fc16 = 0; m_bc2 = 0; m_fc2 = 0;
    end else if (m_halted) begin
      m_valid = 0;
    end else if (m_valid && m_ex.halt) begin
      m_halted = 1;
    end else if (mem_req && !dhit) begin
      if (flush) m_pend = 1;
    end else if (flush || m_pend) begin
      m_ex = '0; m_valid = 0; m_pend = 0;
      if (m_fc16 < 65535) m_fc16++;
      if (m_fc2 < 3) m_fc2++;
    end else if (stall || !ihit) begin
      m_ex = '0; m_valid = 0;
      if (m_bc16 < 65535) m_bc16++;
      if (m_bc2 < 3) m_bc2++;
    end else begin
      m_ex = id_in; m_valid = 1;
    end
  endtask

  task automatic cycle();
    #1;
    chk("freeze16", 192'(bus16.freeze), 192'(mem_req && !dhit && !m_halted));
    chk("freeze2", 192'(bus2.freeze), 192'(mem_req && !dhit && !m_halted));
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    chk("ex_out16", 192'(bus16.ex_out), 192'(m_ex));
    chk("ex_valid16", 192'(bus16.ex_valid), 192'(m_valid));
    chk("halted16", 192'(bus16.halted), 192'(m_halted));
    chk("bubble_cnt16", 192'(bus16.bubble_cnt), 192'(m_bc16));
    chk("flush_cnt16", 192'(bus16.flush_cnt), 192'(m_fc16));
    chk("ex_out2", 192'(bus2.ex_out), 192'(m_ex));
    chk("ex_valid2", 192'(bus2.ex_valid), 192'(m_valid));
    chk("bubble_cnt2", 192'(bus2.bubble_cnt), 192'(m_bc2));
    chk("flush_cnt2", 192'(bus2.flush_cnt), 192'(m_fc2));
  endtask

  task automatic drive(input logic r, input logic ih, input logic mr, input logic dh,
                       input logic st, input logic fl, input logic [31:0] pc, input logic h);
    id_ex_t v;
    rst = r; ihit = ih; mem_req = mr; dhit = dh; stall = st; flush = fl;
    rand_id(pc, h, v);
    id_in = v;
    cycle();
  endtask

  initial begin
    rst = 1; ihit = 0; mem_req = 0; dhit = 0; stall = 0; flush = 0; id_in = '0;
    m_ex = '0; m_valid = 0; m_halted = 0; m_pend = 0;
    m_bc16 = 0; m_fc16 = 0; m_bc2 = 0; m_fc2 = 0;

    //      rst ih mr dh st fl pc     halt
    drive(1, 0, 0, 0, 0, 0, 32'h0,  0);
    drive(1, 1, 1, 0, 1, 1, 32'h0,  0);
    // normal flow
    drive(0, 1, 0, 0, 0, 0, 32'h0,  0);
    drive(0, 1, 0, 0, 0, 0, 32'h4,  0);
    drive(0, 1, 0, 0, 0, 0, 32'h8,  0);
    // stall then reload
    drive(0, 1, 0, 0, 1, 0, 32'h10, 0);
    drive(0, 1, 0, 0, 0, 0, 32'h10, 0);
    // deferred flush across a 3-cycle memory wait
    drive(0, 1, 1, 0, 0, 0, 32'h14, 0);
    drive(0, 1, 1, 0, 0, 1, 32'h14, 0);
    drive(0, 1, 1, 0, 1, 0, 32'h14, 0);
    drive(0, 1, 1, 1, 0, 0, 32'h14, 0);
    drive(0, 1, 0, 0, 0, 0, 32'h18, 0);
    // flush and stall together
    drive(0, 1, 0, 0, 1, 1, 32'h1c, 0);
    // five stalls saturate the 2-bit counter
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 1, 0, 32'h20, 0);
    // reset in the middle of a wait drops the pending flush
    drive(0, 1, 0, 0, 0, 0, 32'h24, 0);
    drive(0, 1, 1, 0, 0, 1, 32'h28, 0);
    drive(1, 1, 1, 0, 0, 0, 32'h28, 0);
    drive(0, 1, 1, 1, 0, 0, 32'h2c, 0);
    // halt becomes sticky and ignores everything until reset
    drive(0, 1, 0, 0, 0, 0, 32'h40, 1);
    drive(0, 1, 0, 0, 0, 0, 32'h44, 0);
    drive(0, 1, 1, 0, 1, 1, 32'h48, 0);
    drive(0, 1, 0, 0, 0, 1, 32'h4c, 0);
    drive(0, 1, 0, 0, 1, 0, 32'h50, 0);
    drive(1, 0, 0, 0, 0, 0, 32'h0,  0);
    drive(0, 1, 0, 0, 0, 0, 32'h54, 0);

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) < 2),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 7) == 0),
            {$urandom_range(0, 32'h3fff_ffff), 2'b00},
            ($urandom_range(0, 29) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
